lux_display_sequencer: RTL and testbench
========================================

Name: lux_display_sequencer

Overview:
Sits between the I2C_BH1750 lux output and the LCD1602 controller, replacing the fixed top-level startup counter and raw-number hookup.
- Holds off for a parametrised startup time.
- Computes a sliding average over 2^AVG_LOG2 lux samples.
- Converts the average to blanked BCD digits with a sequential double-dabble.
- Presents the digits to the LCD side through a valid/ready handshake.
- Adds a hysteresis threshold alarm and a stale-sensor flag.

Parameters:
SYS_CLK_FREQ, 50_000_000, clk frequency in Hz
STARTUP_MS, 100, startup hold time; STARTUP_CYCLES = (SYS_CLK_FREQ/1000)*STARTUP_MS
DATA_W, 16, sample width in bits
AVG_LOG2, 2, log2 of averaging window depth; legal range 0..4
NUM_DIGITS, 5, BCD digit count; must hold 2^DATA_W-1
THRESH_HI, 1000, alarm set level (avg >= THRESH_HI)
THRESH_LO, 800, alarm clear level (avg <= THRESH_LO); must be < THRESH_HI
TIMEOUT_MS, 500, stale timeout; TIMEOUT_CYCLES = (SYS_CLK_FREQ/1000)*TIMEOUT_MS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_i  in  DATA_W  lux sample
sample_valid_i  in  1  one-cycle qualifier for sample_i
disp_ready_i  in  1  LCD side accepts digits_o
disp_valid_o  out  1  digits_o holds a new value
digits_o  out  4*NUM_DIGITS  BCD digits; [3:0] = least significant; 4'hF = blank
avg_o  out  DATA_W  current averaged value
alarm_o  out  1  hysteresis alarm
stale_o  out  1  no sample for TIMEOUT_CYCLES
startup_done_o  out  1  startup hold complete
busy_o  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: clk is the single clock. reset is synchronous and active-high.
- Reset values: all outputs 0, including digits_o = 0 and startup_done_o = 0. The averaging buffer, sum, fill count, pending flag and all counters are cleared. Reset mid-operation aborts any conversion or presentation with no partial output, and the startup hold restarts.
- Startup hold:
  - Counter increments every cycle after reset.
  - startup_done_o rises the cycle after the counter reaches STARTUP_CYCLES, then stays 1 until reset.
  - sample_valid_i is ignored while startup_done_o = 0.
- Averaging:
  - Circular buffer depth D = 2^AVG_LOG2.
  - Running sum is DATA_W+AVG_LOG2 bits wide; on each accepted sample, sum <= sum + new - oldest.
  - avg = sum >> AVG_LOG2 (truncating).
  - avg_o and the pending flag update the cycle after acceptance, but only once the fill count reaches D; before that avg_o is unchanged. After the window is full, every sample updates avg_o.
  - With AVG_LOG2 = 0, avg_o = last sample.
  - Samples are accepted in every FSM state; nothing is dropped.
- FSM states:
  - IDLE: if pending, latch avg_o into the conversion register, clear pending, go to CONV.
  - CONV: shift-add-3 double-dabble, one bit per cycle, DATA_W cycles. Then apply leading-zero blanking: digits above the most significant nonzero digit become 4'hF; value 0 shows a single 0 in the LSD. Load digits_o and go to PRESENT.
  - PRESENT: disp_valid_o = 1 and digits_o is held stable. On disp_valid_o & disp_ready_i, go to IDLE and deassert disp_valid_o on the next cycle.
  - A pending set during CONV or PRESENT is serviced at the next IDLE, using the latest avg_o; intermediate averages are coalesced.
- Latency: sample accepted at edge t → avg_o at t+1 → CONV from t+2 → disp_valid_o at t+2+DATA_W, when the FSM was IDLE and the window was full. If disp_ready_i = 1 in that cycle, disp_valid_o is high for exactly one cycle.
- Alarm: evaluated on each avg_o update. Set if avg >= THRESH_HI; cleared if avg <= THRESH_LO; otherwise held.
- Stale:
  - Counter runs only after startup_done_o, resets on each accepted sample, and saturates.
  - stale_o = 1 while count >= TIMEOUT_CYCLES.
  - stale_o clears the cycle after the next accepted sample.
  - A sample arriving in the same cycle the counter reaches the limit counts as a sample, so stale_o does not assert.

Test Plan:
- Startup: SYS_CLK_FREQ=1000, STARTUP_MS=10. Sample pulses at cycles 0..9 → ignored, avg_o stays 0. startup_done_o rises at cycle 11; the first sample after that is accepted.
- Averaging, AVG_LOG2=2: samples 100, 200, 300, 400 → avg_o = 250, digits_o = 20'hFF250, disp_valid_o exactly DATA_W+2 cycles after the 400 sample. Next sample 800 → avg_o = 425, digits_o = 20'hFF425.
- Boundaries, AVG_LOG2=0: sample 65535 → digits_o = 20'h65535. Sample 0 → digits_o = 20'hFFFF0.
- Backpressure: hold disp_ready_i = 0 in PRESENT and send samples 500, then 600 → digits_o stable and disp_valid_o held. Release disp_ready_i → next presentation carries the 600-derived average only.
- Alarm, AVG_LOG2=0: samples 1000 → alarm_o = 1; 900 → stays 1; 800 → clears; 999 → stays 0.
- Stale and reset: TIMEOUT_MS=5 at 1 kHz, no samples → stale_o = 1 after 5 cycles, cleared by the next sample. Assert reset mid-CONV → outputs 0, busy_o = 0, startup hold restarts, no disp_valid_o pulse.

Source files
------------

// File: rtl/lux_display_sequencer_if.sv
// Lux sensor to LCD sequencer bus: sample input, display handshake and status.
// Latency: pure wiring, no storage.
// Backpressure: disp_ready_i from the LCD side holds the presented digits.
interface lux_display_sequencer_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
);
  logic [DATA_W-1:0]       sample_i;
  logic                    sample_valid_i;
  logic                    disp_ready_i;
  logic                    disp_valid_o;
  logic [4*NUM_DIGITS-1:0] digits_o;
  logic [DATA_W-1:0]       avg_o;
  logic                    alarm_o;
  logic                    stale_o;
  logic                    startup_done_o;
  logic                    busy_o;

  // Environment side: sensor samples in, LCD ready in, display/status observed.
  modport master (
    output sample_i, sample_valid_i, disp_ready_i,
    input  disp_valid_o, digits_o, avg_o, alarm_o, stale_o, startup_done_o, busy_o
  );

  // Sequencer side.
  modport slave (
    input  sample_i, sample_valid_i, disp_ready_i,
    output disp_valid_o, digits_o, avg_o, alarm_o, stale_o, startup_done_o, busy_o
  );
endinterface

// File: rtl/lux_display_sequencer.sv
// Startup hold, sliding average, sequential BCD conversion and LCD handshake for lux samples.
// Latency: sample at edge t -> avg_o at t+1 -> disp_valid_o at t+2+DATA_W when idle and window full.
// Backpressure: digits held while disp_ready_i is low; newer averages coalesce into one pending refresh.
module lux_display_sequencer #(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int STARTUP_MS   = 100,
  parameter int DATA_W       = 16,
  parameter int AVG_LOG2     = 2,
  parameter int NUM_DIGITS   = 5,
  parameter int THRESH_HI    = 1000,
  parameter int THRESH_LO    = 800,
  parameter int TIMEOUT_MS   = 500
) (
  input logic                   clk,
  input logic                   reset,
  lux_display_sequencer_if.slave bus
);

  localparam int STARTUP_CYCLES = (SYS_CLK_FREQ / 1000) * STARTUP_MS;
  localparam int TIMEOUT_CYCLES = (SYS_CLK_FREQ / 1000) * TIMEOUT_MS;
  localparam int SCW    = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam int TCW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DEPTH  = 1 << AVG_LOG2;
  // Pointer is at least one bit wide so a single-entry window still has a legal index.
  localparam int PW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int WSLOTS = 1 << PW;
  localparam int FW     = AVG_LOG2 + 1;
  localparam int SUMW   = DATA_W + AVG_LOG2;
  localparam int BW     = 4 * NUM_DIGITS;
  localparam int BCW    = $clog2(DATA_W + 1);

  localparam logic [SCW-1:0]    STARTUP_LIM = SCW'(STARTUP_CYCLES);
  localparam logic [TCW-1:0]    TIMEOUT_LIM = TCW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0]     FILL_FULL   = FW'(DEPTH);
  localparam logic [PW-1:0]     PTR_LAST    = PW'(DEPTH - 1);
  localparam logic [DATA_W-1:0] HI_LEVEL    = DATA_W'(THRESH_HI);
  localparam logic [DATA_W-1:0] LO_LEVEL    = DATA_W'(THRESH_LO);
  localparam logic [BCW-1:0]    BIT_LAST    = BCW'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SCW-1:0]    startup_cnt_q;
  logic              startup_done_q;
  logic              accept;

  logic [DATA_W-1:0] win_q [WSLOTS];
  logic [PW-1:0]     wr_ptr_q;
  logic [FW-1:0]     fill_q;
  logic [SUMW-1:0]   sum_q;
  logic              avg_upd_q;
  logic [DATA_W-1:0] avg_new;
  logic [DATA_W-1:0] avg_q;
  logic              pending_q;
  logic              alarm_q;

  logic [TCW-1:0]    stale_cnt_q;

  logic [DATA_W-1:0] bin_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_next;
  logic [BW-1:0]     digits_blank;
  logic [BW-1:0]     digits_q;
  logic [BCW-1:0]    bit_cnt_q;
  logic              last_bit;
  logic              lead;

  logic              busy;
  logic              disp_valid;

  // Samples count only once the startup hold has finished.
  assign accept = bus.sample_valid_i & startup_done_q;

  // Startup hold: count up after reset, flag completion one cycle after the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      startup_cnt_q  <= '0;
      startup_done_q <= 1'b0;
    end else begin
      if (startup_cnt_q != STARTUP_LIM) begin
        startup_cnt_q <= startup_cnt_q + SCW'(1);
      end
      if (startup_cnt_q == STARTUP_LIM) begin
        startup_done_q <= 1'b1;
      end
    end
  end

  // Sliding window: replace the oldest entry and keep the running sum in step.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WSLOTS; i++) begin
        win_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      avg_upd_q <= 1'b0;
    end else begin
      // The sample that completes the window (or any later one) refreshes the average.
      avg_upd_q <= accept && (fill_q >= FILL_FULL - FW'(1));
      if (accept) begin
        win_q[wr_ptr_q] <= bus.sample_i;
        sum_q           <= sum_q + SUMW'(bus.sample_i) - SUMW'(win_q[wr_ptr_q]);
        wr_ptr_q        <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        if (fill_q != FILL_FULL) begin
          fill_q <= fill_q + FW'(1);
        end
      end
    end
  end

  assign avg_new = sum_q[SUMW-1:AVG_LOG2];

  // Average register, hysteresis alarm and the pending-refresh flag (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      avg_q     <= '0;
      alarm_q   <= 1'b0;
      pending_q <= 1'b0;
    end else if (avg_upd_q) begin
      avg_q     <= avg_new;
      pending_q <= 1'b1;
      if (avg_new >= HI_LEVEL) begin
        alarm_q <= 1'b1;
      end else if (avg_new <= LO_LEVEL) begin
        alarm_q <= 1'b0;
      end
    end else if (state_q == ST_IDLE && pending_q) begin
      pending_q <= 1'b0;
    end
  end

  // Stale timer: runs after startup, restarts on every accepted sample, saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stale_cnt_q <= '0;
    end else if (!startup_done_q || accept) begin
      stale_cnt_q <= '0;
    end else if (stale_cnt_q != TIMEOUT_LIM) begin
      stale_cnt_q <= stale_cnt_q + TCW'(1);
    end
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = BW'({bcd_adj, bin_q[DATA_W-1]});
  end

  // Leading-zero blanking on the final conversion result; the LSD is never blanked.
  always_comb begin
    digits_blank = bcd_next;
    lead         = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && bcd_next[4*i +: 4] == 4'd0) begin
        digits_blank[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end

  assign last_bit = (bit_cnt_q == BIT_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pending_q)        state_d = ST_CONV;
      ST_CONV:    if (last_bit)         state_d = ST_PRESENT;
      ST_PRESENT: if (bus.disp_ready_i) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    disp_valid = (state_q == ST_PRESENT);
  end

  // Conversion datapath: latch the average on entry, shift one bit per cycle, publish digits at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      digits_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            bin_q     <= avg_q;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        ST_CONV: begin
          bin_q     <= {bin_q[DATA_W-2:0], 1'b0};
          bcd_q     <= bcd_next;
          bit_cnt_q <= bit_cnt_q + BCW'(1);
          if (last_bit) begin
            digits_q <= digits_blank;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.disp_valid_o   = disp_valid;
  assign bus.digits_o       = digits_q;
  assign bus.avg_o          = avg_q;
  assign bus.alarm_o        = alarm_q;
  assign bus.stale_o        = startup_done_q && (stale_cnt_q >= TIMEOUT_LIM);
  assign bus.startup_done_o = startup_done_q;
  assign bus.busy_o         = busy;

endmodule

// File: tb/tb_lux_display_sequencer.sv
// Bench for lux_display_sequencer: two instances (4-sample window and 1-sample window) at 1 kHz.
// Latency: model predicts every output after each clock edge; compared on the falling edge.
// Backpressure: directed holds of disp_ready_i on the single-sample instance.
module tb_lux_display_sequencer;
  localparam int DW      = 16;
  localparam int ND      = 5;
  localparam int STARTUP = 10;
  localparam int TMO     = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lux_display_sequencer_if #(.DATA_W(DW), .NUM_DIGITS(ND)) ifa ();
  lux_display_sequencer_if #(.DATA_W(DW), .NUM_DIGITS(ND)) ifb ();

  lux_display_sequencer #(
    .SYS_CLK_FREQ(1000), .STARTUP_MS(10), .DATA_W(DW), .AVG_LOG2(2), .NUM_DIGITS(ND),
    .THRESH_HI(1000), .THRESH_LO(800), .TIMEOUT_MS(5)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

  lux_display_sequencer #(
    .SYS_CLK_FREQ(1000), .STARTUP_MS(10), .DATA_W(DW), .AVG_LOG2(0), .NUM_DIGITS(ND),
    .THRESH_HI(1000), .THRESH_LO(800), .TIMEOUT_MS(5)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic        svld [2];
  logic [15:0] sval [2];
  logic        rdy  [2];

  assign ifa.sample_valid_i = svld[0];
  assign ifa.sample_i       = sval[0];
  assign ifa.disp_ready_i   = rdy[0];
  assign ifb.sample_valid_i = svld[1];
  assign ifb.sample_i       = sval[1];
  assign ifb.disp_ready_i   = rdy[1];

  logic        o_vld [2];
  logic [19:0] o_dig [2];
  logic [15:0] o_avg [2];
  logic        o_alarm [2];
  logic        o_stale [2];
  logic        o_done [2];
  logic        o_busy [2];

  assign o_vld[0] = ifa.disp_valid_o;   assign o_vld[1] = ifb.disp_valid_o;
  assign o_dig[0] = ifa.digits_o;       assign o_dig[1] = ifb.digits_o;
  assign o_avg[0] = ifa.avg_o;          assign o_avg[1] = ifb.avg_o;
  assign o_alarm[0] = ifa.alarm_o;      assign o_alarm[1] = ifb.alarm_o;
  assign o_stale[0] = ifa.stale_o;      assign o_stale[1] = ifb.stale_o;
  assign o_done[0] = ifa.startup_done_o; assign o_done[1] = ifb.startup_done_o;
  assign o_busy[0] = ifa.busy_o;        assign o_busy[1] = ifb.busy_o;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Decimal digits by division, then leading zeros shown as blanks (LSD always shown).
  function automatic logic [19:0] fmt(input int v);
    logic [19:0] r;
    int x;
    bit lz;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    lz = 1'b1;
    for (int i = ND - 1; i > 0; i--) begin
      if (lz && r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
      else lz = 1'b0;
    end
    return r;
  endfunction

  // Model: events keyed on edge numbers since reset release.
  bit          m_live = 1'b0;
  int          m_edge [2];
  int          m_anchor [2];
  int          m_ready_at [2];
  int          m_nacc [2];
  int          m_next_avg [2];
  int          m_conv_val [2];
  bit          m_conv [2];
  bit          m_show [2];
  bit          m_pend [2];
  bit          m_upd [2];
  int          hist [2][16];
  bit          e_vld [2];
  logic [19:0] e_dig [2];
  int          e_avg [2];
  bit          e_alarm [2];
  bit          e_stale [2];
  bit          e_done [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int dep;
      bit acc;
      int s;
      dep = (k == 0) ? 4 : 1;
      if (reset) begin
        m_live = 1'b1;
        m_edge[k] = 0; m_anchor[k] = 0; m_ready_at[k] = 0; m_nacc[k] = 0;
        m_next_avg[k] = 0; m_conv_val[k] = 0;
        m_conv[k] = 0; m_show[k] = 0; m_pend[k] = 0; m_upd[k] = 0;
        for (int j = 0; j < 16; j++) hist[k][j] = 0;
        e_vld[k] = 0; e_dig[k] = '0; e_avg[k] = 0; e_alarm[k] = 0; e_stale[k] = 0; e_done[k] = 0;
      end else begin
        m_edge[k]++;
        acc = svld[k] && e_done[k];
        // Display path, decided from the situation before this edge.
        if (m_show[k]) begin
          if (rdy[k]) m_show[k] = 0;
        end else if (m_conv[k]) begin
          if (m_edge[k] == m_ready_at[k]) begin
            m_conv[k] = 0;
            m_show[k] = 1;
            e_dig[k] = fmt(m_conv_val[k]);
          end
        end else if (m_pend[k]) begin
          m_conv[k] = 1;
          m_conv_val[k] = e_avg[k];
          m_ready_at[k] = m_edge[k] + DW;
          m_pend[k] = 0;
        end
        // Average published one edge after the sample that produced it.
        if (m_upd[k]) begin
          e_avg[k] = m_next_avg[k];
          m_pend[k] = 1;
          if (e_avg[k] >= 1000) e_alarm[k] = 1;
          else if (e_avg[k] <= 800) e_alarm[k] = 0;
        end
        m_upd[k] = 0;
        if (acc) begin
          for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
          hist[k][0] = int'(sval[k]);
          m_nacc[k]++;
          m_anchor[k] = m_edge[k];
          if (m_nacc[k] >= dep) begin
            s = 0;
            for (int j = 0; j < dep; j++) s += hist[k][j];
            m_next_avg[k] = s / dep;
            m_upd[k] = 1;
          end
        end
        if (!e_done[k] && m_edge[k] >= STARTUP + 1) begin
          e_done[k] = 1;
          m_anchor[k] = m_edge[k];
        end
        e_stale[k] = e_done[k] && (m_edge[k] - m_anchor[k] >= TMO);
        e_vld[k] = m_show[k];
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        check("disp_valid", k, 32'(o_vld[k]), 32'(e_vld[k]));
        check("digits", k, 32'(o_dig[k]), 32'(e_dig[k]));
        check("avg", k, 32'(o_avg[k]), 32'(e_avg[k]));
        check("alarm", k, 32'(o_alarm[k]), 32'(e_alarm[k]));
        check("stale", k, 32'(o_stale[k]), 32'(e_stale[k]));
        check("startup_done", k, 32'(o_done[k]), 32'(e_done[k]));
        check("busy", k, 32'(o_busy[k]), 32'(m_conv[k] | m_show[k]));
      end
    end
  end

  task automatic send(input int k, input logic [15:0] v);
    svld[k] = 1'b1;
    sval[k] = v;
    @(negedge clk);
    svld[k] = 1'b0;
  endtask

  task automatic wait_show(input int k, input int bound, output int n);
    n = 0;
    while (o_vld[k] !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("show_timeout", k, 32'(o_vld[k]), 32'd1);
  endtask

  initial begin
    int n;
    int pulses;
    svld[0] = 0; svld[1] = 0; sval[0] = '0; sval[1] = '0; rdy[0] = 1; rdy[1] = 1;
    repeat (3) @(negedge clk);
    check("reset_digits", 0, 32'(o_dig[0]), 32'h0);
    check("reset_done", 1, 32'(o_done[1]), 32'h0);
    reset = 1'b0;

    // Startup hold: ten early pulses are ignored.
    for (int i = 0; i < 10; i++) begin
      svld[0] = 1; svld[1] = 1; sval[0] = 16'd77; sval[1] = 16'd77;
      @(negedge clk);
    end
    svld[0] = 0; svld[1] = 0;
    check("hold_done_lo", 0, 32'(o_done[0]), 32'h0);
    check("hold_avg", 1, 32'(o_avg[1]), 32'h0);
    @(negedge clk);
    check("hold_done_hi", 0, 32'(o_done[0]), 32'h1);

    // Stale boundary: set exactly five cycles after startup completes.
    repeat (4) @(negedge clk);
    check("stale_lo", 0, 32'(o_stale[0]), 32'h0);
    @(negedge clk);
    check("stale_hi", 0, 32'(o_stale[0]), 32'h1);

    // Four-sample window.
    send(0, 16'd100);
    check("stale_clr", 0, 32'(o_stale[0]), 32'h0);
    send(0, 16'd200);
    send(0, 16'd300);
    send(0, 16'd400);
    wait_show(0, 40, n);
    check("latency", 0, 32'(n), 32'd18);
    check("digits_250", 0, 32'(o_dig[0]), 32'hFF250);
    check("avg_250", 0, 32'(o_avg[0]), 32'd250);
    @(negedge clk);
    check("one_cycle_vld", 0, 32'(o_vld[0]), 32'h0);
    send(0, 16'd800);
    wait_show(0, 40, n);
    check("digits_425", 0, 32'(o_dig[0]), 32'hFF425);
    check("avg_425", 0, 32'(o_avg[0]), 32'd425);
    @(negedge clk);

    // Single-sample window: extremes.
    send(1, 16'd65535);
    wait_show(1, 40, n);
    check("digits_max", 1, 32'(o_dig[1]), 32'h65535);
    check("alarm_max", 1, 32'(o_alarm[1]), 32'h1);
    @(negedge clk);
    send(1, 16'd0);
    wait_show(1, 40, n);
    check("digits_zero", 1, 32'(o_dig[1]), 32'hFFFF0);
    check("alarm_zero", 1, 32'(o_alarm[1]), 32'h0);
    @(negedge clk);

    // Hysteresis.
    send(1, 16'd1000); @(negedge clk); check("alarm_1000", 1, 32'(o_alarm[1]), 32'h1);
    send(1, 16'd900);  @(negedge clk); check("alarm_900", 1, 32'(o_alarm[1]), 32'h1);
    send(1, 16'd800);  @(negedge clk); check("alarm_800", 1, 32'(o_alarm[1]), 32'h0);
    send(1, 16'd999);  @(negedge clk); check("alarm_999", 1, 32'(o_alarm[1]), 32'h0);
    repeat (45) @(negedge clk);

    // Backpressure: 600 arrives while 500 is held on the display.
    rdy[1] = 0;
    send(1, 16'd500);
    wait_show(1, 40, n);
    check("bp_digits_500", 1, 32'(o_dig[1]), 32'hFF500);
    send(1, 16'd600);
    repeat (30) @(negedge clk);
    check("bp_held_vld", 1, 32'(o_vld[1]), 32'h1);
    check("bp_held_dig", 1, 32'(o_dig[1]), 32'hFF500);
    check("bp_avg_600", 1, 32'(o_avg[1]), 32'd600);
    rdy[1] = 1;
    @(negedge clk);
    check("bp_release", 1, 32'(o_vld[1]), 32'h0);
    wait_show(1, 40, n);
    check("bp_digits_600", 1, 32'(o_dig[1]), 32'hFF600);
    @(negedge clk);

    // Reset in the middle of a conversion.
    send(0, 16'd1000);
    repeat (5) @(negedge clk);
    check("conv_busy", 0, 32'(o_busy[0]), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 0, 32'(o_busy[0]), 32'h0);
    check("rst_digits", 0, 32'(o_dig[0]), 32'h0);
    check("rst_avg", 0, 32'(o_avg[0]), 32'h0);
    check("rst_done", 0, 32'(o_done[0]), 32'h0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (o_vld[0] === 1'b1) pulses++;
      if (i == 10) check("restart_done_lo", 0, 32'(o_done[0]), 32'h0);
      if (i == 11) check("restart_done_hi", 0, 32'(o_done[0]), 32'h1);
    end
    check("no_pulse_after_reset", 0, 32'(pulses), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
